// File: rtl/mem_access_unit_pkg.sv
// Shared pipeline definitions: datapath widths and the MEM-stage FSM encoding.
package mem_access_unit_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mau_state_e;

    // Data memory is word addressed; the byte offset is dropped.
    function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] addr);
        return addr & ~(DATA_W'(3));
    endfunction

endpackage

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: passes ALU results straight through and runs loads/stores
// to data memory as a stalling IDLE -> ACCESS -> DONE sequence.
module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] EX_MEM_ALU_out,
    input  logic [DATA_W-1:0] EX_MEM_rt_data,
    input  logic [REG_W-1:0]  EX_MEM_Rd,
    input  logic              EX_MEM_RegWrite,
    input  logic              EX_MEM_MemRead,
    input  logic              EX_MEM_MemWrite,
    input  logic              EX_MEM_MemtoReg,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic [DATA_W-1:0] MEM_write_data,
    output logic [REG_W-1:0]  MEM_Rd,
    output logic              MEM_RegWrite,
    output logic              MEM_stall
);

    mau_state_e        state_q, state_d;
    logic [DATA_W-1:0] load_q,  load_d;
    logic              mem_op;

    assign mem_op = EX_MEM_MemRead | EX_MEM_MemWrite;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            load_q  <= '0;
        end else begin
            state_q <= state_d;
            load_q  <= load_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        load_d         = load_q;
        dmem_req       = 1'b0;
        dmem_we        = 1'b0;
        dmem_addr      = '0;
        dmem_wdata     = '0;
        MEM_write_data = EX_MEM_ALU_out;
        MEM_Rd         = EX_MEM_Rd;
        MEM_RegWrite   = EX_MEM_RegWrite;
        MEM_stall      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_op) begin
                    MEM_stall    = 1'b1;
                    MEM_RegWrite = 1'b0;
                    state_d      = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // A combined read+write is issued as a write; rdata is still captured.
                dmem_req     = 1'b1;
                dmem_we      = EX_MEM_MemWrite;
                dmem_addr    = word_align(EX_MEM_ALU_out);
                dmem_wdata   = EX_MEM_rt_data;
                MEM_stall    = 1'b1;
                MEM_RegWrite = 1'b0;
                if (dmem_ready) begin
                    load_d  = dmem_rdata;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (EX_MEM_MemtoReg) begin
                    MEM_write_data = load_q;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit with a word-addressed memory responder.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] EX_MEM_ALU_out, EX_MEM_rt_data;
    logic [4:0]  EX_MEM_Rd;
    logic        EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemtoReg;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic [31:0] MEM_write_data;
    logic [4:0]  MEM_Rd;
    logic        MEM_RegWrite, MEM_stall;

    mem_access_unit dut (
        .clk(clk), .reset(reset),
        .EX_MEM_ALU_out(EX_MEM_ALU_out), .EX_MEM_rt_data(EX_MEM_rt_data),
        .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .EX_MEM_MemtoReg(EX_MEM_MemtoReg),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .MEM_write_data(MEM_write_data), .MEM_Rd(MEM_Rd),
        .MEM_RegWrite(MEM_RegWrite), .MEM_stall(MEM_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          waits;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
    } ret_t;

    req_t req_q[$];
    ret_t ret_q[$];
    bit [31:0] ref_mem [bit [31:0]];
    bit [31:0] dev_mem [bit [31:0]];

    int vectors = 0;
    int errors  = 0;
    bit mon_en  = 0;
    bit resp_en = 0;

    function automatic bit [31:0] init_word(input bit [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic bit [31:0] ref_read(input bit [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    function automatic bit [31:0] dev_read(input bit [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : init_word(a);
    endfunction

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Scoreboard monitor: every unstalled cycle retires exactly one instruction.
    always @(negedge clk) begin
        ret_t t;
        if (mon_en) begin
            if (MEM_stall === 1'b1) begin
                chk("stall_regwrite", {31'd0, MEM_RegWrite}, 32'd0);
            end else if (ret_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_retire: got rd=%0d expected none at %0t", MEM_Rd, $time);
            end else begin
                t = ret_q.pop_front();
                chk("retire_data", MEM_write_data, t.data);
                chk("retire_rd", {27'd0, MEM_Rd}, {27'd0, t.rd});
                chk("retire_regwrite", {31'd0, MEM_RegWrite}, {31'd0, t.rw});
            end
        end
    end

    // Memory responder: checks each request cycle and answers after the planned wait.
    bit active = 0;
    int wait_cnt = 0;
    always @(negedge clk) begin
        req_t r;
        if (!resp_en) begin
            dmem_ready = 1'b0;
            dmem_rdata = $urandom;
        end else if (dmem_req === 1'b1) begin
            if (req_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_req: got addr 0x%08h expected no request", dmem_addr);
                dmem_ready = 1'b1;
                dmem_rdata = 32'd0;
            end else begin
                r = req_q[0];
                chk("req_addr", dmem_addr, r.addr);
                chk("req_we", {31'd0, dmem_we}, {31'd0, r.we});
                chk("req_wdata", dmem_wdata, r.wdata);
                if (!active) begin
                    active   = 1;
                    wait_cnt = r.waits;
                end
                if (wait_cnt == 0) begin
                    dmem_ready = 1'b1;
                    dmem_rdata = dev_read(r.addr);
                    if (r.we) dev_mem[r.addr] = r.wdata;
                    void'(req_q.pop_front());
                    active = 0;
                end else begin
                    wait_cnt--;
                    dmem_ready = 1'b0;
                    dmem_rdata = $urandom;
                end
            end
        end else begin
            chk("idle_we", {31'd0, dmem_we}, 32'd0);
            chk("idle_addr", dmem_addr, 32'd0);
            chk("idle_wdata", dmem_wdata, 32'd0);
            dmem_ready = 1'($urandom_range(0, 1));
            dmem_rdata = $urandom;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the instruction retires.
    task automatic run_op(input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mw, input logic m2r,
                          input int waits);
        req_t r;
        ret_t t;
        logic mem;
        logic [31:0] aa;
        int lat, explat;
        EX_MEM_ALU_out  = alu;
        EX_MEM_rt_data  = rt;
        EX_MEM_Rd       = rd;
        EX_MEM_RegWrite = rw;
        EX_MEM_MemRead  = mr;
        EX_MEM_MemWrite = mw;
        EX_MEM_MemtoReg = m2r;
        mem = mr | mw;
        aa  = {alu[31:2], 2'b00};
        if (mem) begin
            r.addr = aa; r.we = mw; r.wdata = rt; r.waits = waits;
            req_q.push_back(r);
        end
        t.rd   = rd;
        t.rw   = rw;
        t.data = (mem && m2r) ? ref_read(aa) : alu;
        if (mw) ref_mem[aa] = rt;
        ret_q.push_back(t);
        explat = mem ? 3 + waits : 1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (MEM_stall === 1'b1 && lat < 64);
        chk("latency", 32'(lat), 32'(explat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        EX_MEM_ALU_out = '0; EX_MEM_rt_data = '0; EX_MEM_Rd = '0;
        EX_MEM_RegWrite = 0; EX_MEM_MemRead = 0; EX_MEM_MemWrite = 0; EX_MEM_MemtoReg = 0;
        dmem_ready = 0; dmem_rdata = '0;
        ref_mem[32'h104] = 32'hDEAD_BEEF;
        dev_mem[32'h104] = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_req", {31'd0, dmem_req}, 32'd0);
        chk("reset_stall", {31'd0, MEM_stall}, 32'd0);
        @(posedge clk);
        #1;
        mon_en = 1; resp_en = 1;

        run_op(32'h10, 32'h0, 5'd5, 1, 0, 0, 0, 0);
        run_op(32'h107, 32'h0, 5'd8, 1, 1, 0, 1, 0);
        run_op(32'h20, 32'h1234_5678, 5'd0, 0, 0, 1, 0, 2);
        run_op(32'h40, 32'h0, 5'd9, 1, 1, 0, 1, 0);
        run_op(32'h44, 32'h0, 5'd10, 1, 1, 0, 1, 0);
        run_op(32'h20, 32'h0, 5'd11, 1, 1, 0, 1, 1);
        run_op(32'h1F3, 32'hCAFE_F00D, 5'd12, 1, 1, 1, 1, 1);
        run_op(32'h1F0, 32'h0, 5'd13, 1, 1, 0, 1, 0);

        // Reset during the second ACCESS cycle of a stalled load.
        mon_en = 0; resp_en = 0;
        EX_MEM_ALU_out = 32'h80; EX_MEM_Rd = 5'd7; EX_MEM_RegWrite = 1;
        EX_MEM_MemRead = 1; EX_MEM_MemWrite = 0; EX_MEM_MemtoReg = 1;
        @(negedge clk);
        chk("rst_t0_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_t0_stall", {31'd0, MEM_stall}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_t1_req", {31'd0, dmem_req}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_t2_req", {31'd0, dmem_req}, 32'd1);
        chk("rst_t2_addr", dmem_addr, 32'h80);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        EX_MEM_ALU_out = 32'h55; EX_MEM_Rd = 5'd3; EX_MEM_RegWrite = 1;
        EX_MEM_MemRead = 0; EX_MEM_MemtoReg = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_after_req", {31'd0, dmem_req}, 32'd0);
            chk("rst_after_stall", {31'd0, MEM_stall}, 32'd0);
            chk("rst_after_data", MEM_write_data, 32'h55);
            chk("rst_after_rw", {31'd0, MEM_RegWrite}, 32'd1);
            @(posedge clk); #1;
        end
        mon_en = 1; resp_en = 1;

        for (int n = 0; n < 200; n++) begin
            int kind;
            logic mr, mw;
            kind = $urandom_range(0, 3);
            mr = 0; mw = 0;
            if (kind == 1) mr = 1;
            if (kind == 2) mw = 1;
            if (kind == 3) begin mr = 1; mw = 1; end
            run_op((mr | mw) ? 32'h100 + 32'($urandom_range(0, 255)) : $urandom,
                   $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   mr, mw, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        mon_en = 0; resp_en = 0;
        chk("ret_q_drained", 32'(ret_q.size()), 32'd0);
        chk("req_q_drained", 32'(req_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
